// File: rtl/daa_pkg.sv
// Shared types and constants for the double-and-add arbiter slice.
// Holds FSM states, requester IDs and daa_mode encodings.
package daa_pkg;

    localparam int W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ_KEYGEN = 1'b0;
    localparam logic REQ_SHARED = 1'b1;

    localparam logic [1:0] DAA_MODE_SCALAR_MUL = 2'd0;
    localparam logic [1:0] DAA_MODE_POINT_ADD  = 2'd1;
    localparam logic [1:0] DAA_MODE_POINT_DBL  = 2'd2;
    localparam logic [1:0] DAA_MODE_RESERVED   = 2'd3;

endpackage

// File: rtl/daa_rr_arb2.sv
// Two-way round-robin arbiter: purely combinational, zero latency.
// No backpressure of its own; i_enable gates all grants.
module daa_rr_arb2 (
    input  logic       i_enable,
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    always_comb begin
        o_grant    = 2'b00;
        o_grant_id = 1'b0;
        if (i_enable && (|i_valid)) begin
            // On a tie, the requester that did not win last time goes first.
            if (&i_valid) begin
                o_grant_id = ~i_last_grant;
            end else begin
                o_grant_id = i_valid[1];
            end
            o_grant[o_grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/daa_arbiter.sv
// Shares one DAA scalar-multiply unit between keygen (R0) and shared-secret (R1) requesters.
// Latency: grant cycle, daa_valid next edge, result one edge after daa_finished; rsp held until rsp_ready.
// Optional abort of a hung operation when DAA_TIMEOUT_EN is defined.
module daa_arbiter
    import daa_pkg::*;
#(
    parameter int             W         = daa_pkg::W,
    parameter int             TO_W      = 16,
    parameter logic [TO_W-1:0] TO_CYCLES = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_prime,
    input  logic [W-1:0] cfg_a,
    input  logic [W-1:0] cfg_b,
    output logic         cfg_busy,
    input  logic         r0_valid,
    input  logic         r1_valid,
    output logic         r0_ready,
    output logic         r1_ready,
    input  logic [1:0]   r0_mode,
    input  logic [1:0]   r1_mode,
    input  logic [W-1:0] r0_pointx,
    input  logic [W-1:0] r0_pointy,
    input  logic [W-1:0] r0_mul,
    input  logic [W-1:0] r1_pointx,
    input  logic [W-1:0] r1_pointy,
    input  logic [W-1:0] r1_mul,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_x,
    output logic [W-1:0] rsp_y,
    output logic         rsp_err,
    output logic         daa_valid,
    output logic [1:0]   daa_mode,
    output logic [W-1:0] daa_pointx,
    output logic [W-1:0] daa_pointy,
    output logic [W-1:0] daa_prime,
    output logic [W-1:0] daa_a,
    output logic [W-1:0] daa_b,
    output logic [W-1:0] daa_mul,
    input  logic         daa_finished,
    input  logic [W-1:0] daa_outx,
    input  logic [W-1:0] daa_outy
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic         r_id;
    logic [1:0]   r_mode;
    logic [W-1:0] r_pointx;
    logic [W-1:0] r_pointy;
    logic [W-1:0] r_mul;
    logic [W-1:0] r_prime;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_rsp_x;
    logic [W-1:0] r_rsp_y;
    logic         r_rsp_err;
    logic [1:0]   w_grant;
    logic         w_grant_id;
    logic         w_any_grant;
    logic         w_arb_en;
    logic         w_timeout;

    // Gating with rst keeps the grant pulses low while reset is held.
    assign w_arb_en    = (r_state == IDLE) && rst;
    assign w_any_grant = |w_grant;

    daa_rr_arb2 u_arb (
        .i_enable     (w_arb_en),
        .i_valid      ({r1_valid, r0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_id   (w_grant_id)
    );

`ifdef DAA_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == RUN) && (r_to_cnt == TO_CYCLES - TO_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_any_grant) begin
            r_to_cnt <= '0;
        end else if (r_state == RUN) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    logic w_unused_to;

    assign w_timeout   = 1'b0;
    assign w_unused_to = ^{TO_CYCLES, TO_W[0]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_grant) w_state_nxt = RUN;
            RUN:     if (daa_finished || w_timeout) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prime      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_last_grant <= REQ_SHARED;
            r_id         <= REQ_KEYGEN;
            r_mode       <= '0;
            r_pointx     <= '0;
            r_pointy     <= '0;
            r_mul        <= '0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if ((r_state == IDLE) && cfg_load) begin
                r_prime <= cfg_prime;
                r_a     <= cfg_a;
                r_b     <= cfg_b;
            end
            if (w_any_grant) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_mode       <= w_grant_id ? r1_mode   : r0_mode;
                r_pointx     <= w_grant_id ? r1_pointx : r0_pointx;
                r_pointy     <= w_grant_id ? r1_pointy : r0_pointy;
                r_mul        <= w_grant_id ? r1_mul    : r0_mul;
            end
            // A real result beats a timeout landing in the same cycle.
            if ((r_state == RUN) && daa_finished) begin
                r_rsp_x   <= daa_outx;
                r_rsp_y   <= daa_outy;
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_x   <= '0;
                r_rsp_y   <= '0;
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign cfg_busy   = (r_state != IDLE);
    assign r0_ready   = w_grant[0];
    assign r1_ready   = w_grant[1];
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_x      = r_rsp_x;
    assign rsp_y      = r_rsp_y;
`ifdef DAA_TIMEOUT_EN
    assign rsp_err    = r_rsp_err;
`else
    assign rsp_err    = 1'b0;
`endif
    assign daa_valid  = (r_state == RUN);
    assign daa_mode   = r_mode;
    assign daa_pointx = r_pointx;
    assign daa_pointy = r_pointy;
    assign daa_mul    = r_mul;
    // Config cannot change outside IDLE, so the live registers are stable for the whole operation.
    assign daa_prime  = r_prime;
    assign daa_a      = r_a;
    assign daa_b      = r_b;

endmodule

// File: doc/daa_arbiter.md
Name: daa_arbiter

Overview:
- Shares one double_and_add_always scalar-multiply unit between two requesters (R0 = key generation, R1 = shared-secret derivation).
- Holds the shared curve configuration (prime, a, b).
- Arbitrates requests round-robin, latches operands and holds daa_valid high for the whole operation.
- Captures the one-cycle finished result and returns it through a valid/ready response port tagged with the requester ID.

Parameters:
- W, 256, operand and coordinate width.
- TO_W, 16, width of the timeout counter. Used only with DAA_TIMEOUT_EN.
- TO_CYCLES, 16'hFFFF, cycles in WAIT before abort. Used only with DAA_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_load  in  1  load curve config, accepted only when cfg_busy=0
- cfg_prime, cfg_a, cfg_b  in  W each  curve parameters
- cfg_busy  out  1  high in any state except IDLE
- r0_valid, r1_valid  in  1 each  request valid
- r0_ready, r1_ready  out  1 each  request accepted this cycle (grant pulse)
- r0_mode, r1_mode  in  2 each  daa_mode for the request
- r0_pointx, r0_pointy, r0_mul  in  W each  R0 operands
- r1_pointx, r1_pointy, r1_mul  in  W each  R1 operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_x, rsp_y  out  W each  result point
- rsp_err  out  1  result aborted by timeout (always 0 without DAA_TIMEOUT_EN)
- daa_valid  out  1  to DAA unit
- daa_mode  out  2  to DAA unit
- daa_pointx, daa_pointy, daa_prime, daa_a, daa_b, daa_mul  out  W each  to DAA unit
- daa_finished  in  1  from DAA unit, one-cycle pulse
- daa_outx, daa_outy  in  W each  from DAA unit, valid only while daa_finished=1

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so R0 wins the first tie; config registers 0.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - cfg_load=1 updates the prime/a/b registers at the clock edge.
  - If any rX_valid is set, grant one requester: pulse rX_ready for one cycle, latch mode/pointx/pointy/mul, store the ID, then go to RUN.
  - Round-robin: if both request, grant the one not equal to last_grant; last_grant updates on every grant.
  - cfg_load and a request in the same cycle: the config update takes effect, and the granted operation uses the new config.
- RUN:
  - daa_valid=1 every cycle. daa_* operands are driven from the latched registers and held stable.
  - On daa_finished=1, capture daa_outx/daa_outy into rsp registers in that same cycle, deassert daa_valid from the next cycle, and go to RESP.
  - Latency: grant cycle, then daa_valid rises at the next edge.
- RESP:
  - rsp_valid=1; rsp_id/x/y stable.
  - rsp_valid & rsp_ready returns to IDLE; rsp_valid is 0 from the next cycle.
  - No new grant in the handshake cycle; the earliest regrant is the following cycle.
- cfg_load outside IDLE is ignored; config registers are unchanged.
- daa_finished outside RUN is ignored.
- daa_valid must drop for at least one cycle between operations so the DAA unit's internal counter sequence restarts cleanly.
- Reset mid-operation: the FSM returns to IDLE immediately and daa_valid drops asynchronously. Any in-flight result is lost and no response is produced.
- Requesters may drop rX_valid before being granted; no grant occurs in that case.

Optional Feature:
- Macro DAA_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on entry to RUN and increments each RUN cycle.
  - When the count reaches TO_CYCLES without daa_finished: go to RESP with rsp_err=1 and rsp_x=rsp_y=0, and drop daa_valid.
  - If daa_finished and timeout occur in the same cycle, finished wins (rsp_err=0).
- When undefined: no counter, rsp_err tied 0, RUN waits indefinitely.

Decomposition:
- Shared package daa_pkg:
  - State enum {IDLE, RUN, RESP}.
  - Width constant W=256.
  - Requester ID constants REQ_KEYGEN=0, REQ_SHARED=1.
  - daa_mode encodings.
- One natural sub-module, daa_rr_arb2: 2-way round-robin arbiter. Inputs: valid[1:0], last_grant, enable. Outputs: grant one-hot, grant_id.

Test Plan:
- Single request: load cfg prime=7, a=2, b=3; R0 requests with mul=5. Expect r0_ready for 1 cycle, then daa_valid high with daa_mul=5 and daa_prime=7. Stub finishes after 33 cycles with x=32'hDFA978E7, y=32'hF6A1A9BB. Expect rsp_valid, rsp_id=0, matching x/y, daa_valid=0 the next cycle.
- Simultaneous R0/R1 from reset: R0 granted first and R1 second; with both requesting again, R0 granted third (alternation). Response IDs come out as 0, 1, 0.
- Backpressure: hold rsp_ready=0 for 10 cycles. Response stays stable, no new grant, r1_ready stays 0 while R1 is pending; grant occurs 1 cycle after the handshake.
- Config lockout: cfg_load with prime=11 during RUN is ignored, daa_prime stays 7. The same load in IDLE with a simultaneous request gives daa_prime=11.
- Reset mid-RUN: assert rst in cycle 5 of RUN. daa_valid=0 asynchronously, all outputs 0; after release, a new R1 request is granted (tie goes to R0 per last_grant=1).
- DAA_TIMEOUT_EN with TO_CYCLES=20 and a stub that never finishes: at cycle 20, rsp_valid with rsp_err=1 and rsp_x=0. daa_finished arriving in the same cycle gives rsp_err=0.
